// File: rtl/hop_chain_sequencer_if.sv
// Signal bundle between the hop-chain sequencer, the board go/status logic and the chain flops.
// The slave side is the sequencer. The master side is the board plus the chains.
interface hop_chain_sequencer_if #(
   parameter int NUM_CHAINS  = 4,
   parameter int CHAIN_DEPTH = 5
);
   logic                                  go;
   logic [NUM_CHAINS-1:0]                 chain_mask;
   logic [NUM_CHAINS-1:0]                 tail;
   logic                                  head_rst;
   logic [NUM_CHAINS*(CHAIN_DEPTH-1)-1:0] stage_rst;
   logic [NUM_CHAINS-1:0]                 start;
   logic                                  busy;
   logic                                  done;
   logic                                  pass;
   logic [NUM_CHAINS-1:0]                 fail_mask;

   modport master (
      output go, chain_mask, tail,
      input  head_rst, stage_rst, start, busy, done, pass, fail_mask
   );

   modport slave (
      input  go, chain_mask, tail,
      output head_rst, stage_rst, start, busy, done, pass, fail_mask
   );
endinterface

// File: rtl/hop_chain_sequencer.sv
// Releases hop-chain resets column by column, then sends a one-cycle token into each enabled chain.
// Each chain's tail is checked for a single-cycle arrival exactly CHAIN_DEPTH cycles after its start pulse.
module hop_chain_sequencer #(
   parameter int NUM_CHAINS  = 4,
   parameter int CHAIN_DEPTH = 5,
   parameter int REL_GAP     = 2,
   parameter int TIMEOUT     = 12
) (
   input  logic                 clock0,
   input  logic                 rst_n,
   hop_chain_sequencer_if.slave bus
);
   localparam int NUM_COLS = CHAIN_DEPTH - 1;
   localparam int STG_W    = NUM_CHAINS * NUM_COLS;
   localparam int OFF_W    = $clog2(TIMEOUT + 1);
   localparam int REL_W    = $clog2(REL_GAP * CHAIN_DEPTH + 1);
   localparam int IDX_W    = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RELEASE, S_LAUNCH, S_WAIT, S_DONE
   } state_t;

   state_t                r_state;
   logic [NUM_CHAINS-1:0] r_mask;
   logic [NUM_CHAINS-1:0] r_tested;
   logic [NUM_CHAINS-1:0] r_start;
   logic [NUM_CHAINS-1:0] r_fail_mask;
   logic [IDX_W-1:0]      r_cur;
   logic [OFF_W-1:0]      r_off;
   logic [REL_W-1:0]      r_rel;
   logic [STG_W-1:0]      r_stage_rst;
   logic                  r_head_rst;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;

   logic [NUM_CHAINS-1:0] w_pending;
   logic [NUM_CHAINS-1:0] w_next_onehot;
   logic [IDX_W-1:0]      w_next_idx;
   logic                  w_tail_bad;
   logic [NUM_CHAINS-1:0] w_fail_now;

   always_comb begin
      w_pending     = r_mask & ~r_tested;
      w_next_onehot = w_pending & (~w_pending + 1'b1);
      w_next_idx    = '0;
      for (int c = NUM_CHAINS - 1; c >= 0; c--) begin
         if (w_pending[c]) w_next_idx = IDX_W'(c);
      end
      // The tail must be high only at the expected offset. Any other level in the window is a failure.
      w_tail_bad = (r_off == OFF_W'(CHAIN_DEPTH)) ? ~bus.tail[r_cur] : bus.tail[r_cur];
      w_fail_now = r_fail_mask;
      if (r_state == S_WAIT && w_tail_bad) w_fail_now = r_fail_mask | (NUM_CHAINS'(1) << r_cur);
   end

   // NOTE: every register below uses non-blocking assignment.
   // Reads in the same edge then see the previous cycle's values, which matches the flops that are built.
   always_ff @(posedge clock0 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mask      <= '0;
         r_tested    <= '0;
         r_start     <= '0;
         r_fail_mask <= '0;
         r_cur       <= '0;
         r_off       <= '0;
         r_rel       <= '0;
         r_stage_rst <= '1;
         r_head_rst  <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_mask      <= bus.chain_mask;
                  r_tested    <= '0;
                  r_fail_mask <= '0;
                  r_rel       <= '0;
                  r_busy      <= 1'b1;
                  if (bus.chain_mask != '0) begin
                     r_state    <= S_RELEASE;
                     r_head_rst <= 1'b0;
                     r_pass     <= 1'b0;
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_pass  <= 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               for (int k = 0; k < NUM_COLS; k++) begin
                  if (r_rel == REL_W'(REL_GAP * (k + 1) - 1)) begin
                     for (int c = 0; c < NUM_CHAINS; c++) begin
                        if (r_mask[c]) r_stage_rst[c*NUM_COLS+k] <= 1'b0;
                     end
                  end
               end
               if (r_rel == REL_W'(REL_GAP * CHAIN_DEPTH - 1)) begin
                  r_state  <= S_LAUNCH;
                  r_start  <= w_next_onehot;
                  r_cur    <= w_next_idx;
                  r_tested <= r_tested | w_next_onehot;
               end else begin
                  r_rel <= r_rel + 1'b1;
               end
            end
            S_LAUNCH: begin
               r_start <= '0;
               r_off   <= OFF_W'(1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_fail_mask <= w_fail_now;
               if (r_off == OFF_W'(TIMEOUT)) begin
                  if (w_pending != '0) begin
                     r_state  <= S_LAUNCH;
                     r_start  <= w_next_onehot;
                     r_cur    <= w_next_idx;
                     r_tested <= r_tested | w_next_onehot;
                  end else begin
                     // Include the final sample's verdict in pass, because it lands on this same edge.
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_pass      <= (w_fail_now == '0);
                     r_head_rst  <= 1'b1;
                     r_stage_rst <= '1;
                  end
               end else begin
                  r_off <= r_off + 1'b1;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.head_rst  = r_head_rst;
   assign bus.stage_rst = r_stage_rst;
   assign bus.start     = r_start;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.fail_mask = r_fail_mask;
endmodule

// File: tb/tb_hop_chain_sequencer.sv
// Bench for hop_chain_sequencer: behavioural chains with configurable depth or stuck tails,
// and a per-cycle timeline reference built from the run-schedule arithmetic.
module tb_hop_chain_sequencer;
   localparam int NC      = 4;
   localparam int CD      = 5;
   localparam int RG      = 2;
   localparam int TO      = 12;
   localparam int REL_LEN = RG * CD;
   localparam int SLOT    = TO + 1;
   localparam int SW      = NC * (CD - 1);

   logic clock0 = 1'b0;
   logic rst_n  = 1'b0;
   int   n_vec  = 0;
   int   n_err  = 0;
   int   depth [NC];
   bit   stuck [NC];
   logic [15:0] sh [NC];

   hop_chain_sequencer_if #(.NUM_CHAINS(NC), .CHAIN_DEPTH(CD)) bus ();

   hop_chain_sequencer #(
      .NUM_CHAINS(NC), .CHAIN_DEPTH(CD), .REL_GAP(RG), .TIMEOUT(TO)
   ) dut (
      .clock0(clock0),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clock0 = ~clock0;

   // Behavioural chains: the tail is the start pulse delayed by depth[c] flops, or forced high when stuck.
   always @(posedge clock0 or negedge rst_n) begin
      for (int c = 0; c < NC; c++) begin
         if (!rst_n) sh[c] <= '0;
         else        sh[c] <= {sh[c][14:0], bus.start[c]};
      end
   end

   always @* begin
      for (int c = 0; c < NC; c++) bus.tail[c] = stuck[c] | sh[c][4'(depth[c] - 1)];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".head_rst"},  64'(bus.head_rst),  64'(1));
      check({tag, ".stage_rst"}, 64'(bus.stage_rst), 64'({SW{1'b1}}));
      check({tag, ".start"},     64'(bus.start),     64'(0));
      check({tag, ".busy"},      64'(bus.busy),      64'(0));
      check({tag, ".done"},      64'(bus.done),      64'(0));
      check({tag, ".pass"},      64'(bus.pass),      64'(0));
      check({tag, ".fail_mask"}, 64'(bus.fail_mask), 64'(0));
   endtask

   // Called at the sample point of cycle G. Drives go and checks every cycle from G+1 to one cycle past done.
   // A nonzero abort_t pulses rst_n low in that cycle and returns once the reset has been released.
   task automatic run_check(input logic [NC-1:0] mask, input bit keep_go, input int abort_t);
      int en[$];
      int n, done_t, first_bad;
      logic [NC-1:0] exp_fail, exp_fail_t, exp_start;
      logic [SW-1:0] exp_stg;
      for (int c = 0; c < NC; c++) if (mask[c]) en.push_back(c);
      n      = en.size();
      done_t = (n == 0) ? 1 : 1 + REL_LEN + n * SLOT;
      exp_fail = '0;
      foreach (en[j]) if (depth[en[j]] != CD || stuck[en[j]]) exp_fail[en[j]] = 1'b1;
      bus.go         = 1'b1;
      bus.chain_mask = mask;
      for (int t = 1; t <= done_t + 1; t++) begin
         @(posedge clock0);
         #1;
         if (t == 1 && !keep_go) bus.go = 1'b0;
         exp_start  = '0;
         exp_fail_t = '0;
         foreach (en[j]) begin
            if (t == 1 + REL_LEN + j * SLOT) exp_start[en[j]] = 1'b1;
            // The first bad sample is at offset 1 when stuck, an early arrival at offset depth, otherwise offset CD.
            first_bad = stuck[en[j]] ? 1 : (depth[en[j]] < CD ? depth[en[j]] : CD);
            if (exp_fail[en[j]] && t >= 1 + REL_LEN + j * SLOT + first_bad + 1) exp_fail_t[en[j]] = 1'b1;
         end
         exp_stg = '1;
         for (int c = 0; c < NC; c++)
            for (int k = 0; k < CD - 1; k++)
               if (mask[c] && t < done_t && t >= 1 + RG * (k + 1)) exp_stg[c*(CD-1)+k] = 1'b0;
         check("busy",      64'(bus.busy),      64'(t <= done_t));
         check("done",      64'(bus.done),      64'(t == done_t));
         check("start",     64'(bus.start),     64'(exp_start));
         check("head_rst",  64'(bus.head_rst),  64'((n == 0) || (t >= done_t)));
         check("stage_rst", 64'(bus.stage_rst), 64'(exp_stg));
         check("fail_mask", 64'(bus.fail_mask), 64'(exp_fail_t));
         check("pass",      64'(bus.pass),      64'((t >= done_t) && (exp_fail == '0)));
         if (t == abort_t) begin
            rst_n = 1'b0;
            #1;
            check_reset_vals("async_rst");
            @(posedge clock0);
            #1;
            check_reset_vals("held_rst");
            bus.go = 1'b0;
            rst_n  = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      logic [NC-1:0] rmask;
      bus.go         = 1'b0;
      bus.chain_mask = '0;
      for (int c = 0; c < NC; c++) begin
         depth[c] = CD;
         stuck[c] = 1'b0;
      end
      repeat (2) @(posedge clock0);
      #1;
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clock0);
      #1;
      check_reset_vals("idle");

      run_check(4'hF, 1'b0, 0);

      depth[2] = 6;
      run_check(4'hF, 1'b0, 0);
      depth[2] = CD;

      run_check(4'b1010, 1'b0, 0);
      run_check(4'b0000, 1'b0, 0);

      stuck[3] = 1'b1;
      run_check(4'hF, 1'b0, 0);
      stuck[3] = 1'b0;

      run_check(4'hF, 1'b0, 15);
      run_check(4'hF, 1'b0, 0);

      depth[1] = 4;
      run_check(4'hF, 1'b1, 0);
      depth[1] = CD;
      run_check(4'b0111, 1'b0, 0);

      for (int r = 0; r < 10; r++) begin
         rmask = NC'($urandom_range(0, 15));
         for (int c = 0; c < NC; c++) begin
            depth[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 6)) : CD;
            stuck[c] = ($urandom_range(0, 7) == 0);
         end
         run_check(rmask, bit'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded its time bound");
      $fatal(1, "watchdog expired");
   end
endmodule
